priv_mode_ctrl: RTL
===================

Name: priv_mode_ctrl

Overview:
Parametrised privilege-mode controller for one hart. It holds the current privilege level (M/S/U) and the mstatus stacking fields (MPP/SPP/MIE/SIE/MPIE/SPIE), and applies trap entry with delegation, MRET/SRET, and CSR writes. After each mode switch it enforces a programmable settle window so the pipeline can flush. It sits between the trap unit, the CSR file and the fetch/flush logic.

Parameters:
HAS_S, 1, S-mode implemented (0: target always M, SRET illegal, SPP/SIE/SPIE read 0)
HAS_U, 1, U-mode implemented (0: MPP fixed to M)
CAUSE_W, 6, width of trap cause code
NUM_CAUSES, 64, width of medeleg/mideleg vectors (2**CAUSE_W max)
SETTLE_CYCLES, 2, busy cycles after a mode switch (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
trap_valid  in  1  single-cycle trap-entry pulse
trap_is_int  in  1  1 = interrupt (use mideleg), 0 = exception (use medeleg)
trap_cause  in  CAUSE_W  cause code
medeleg  in  NUM_CAUSES  exception delegation bits
mideleg  in  NUM_CAUSES  interrupt delegation bits
xret_valid  in  1  xRET request; held until xret_ready
xret_kind  in  2  xret_kind_e: 2'b11 MRET, 2'b01 SRET
xret_ready  out  1  = !settle_busy
xret_illegal  out  1  one-cycle pulse: xRET accepted but not permitted
status_w_en  in  1  CSR write of stacking fields
status_w  in  priv_status_t  written MPP/SPP/MIE/SIE/MPIE/SPIE
priv_rval  out  2  current privilege_level_e
status_rval  out  priv_status_t  current stacking fields
trap_target  out  2  registered target level of the last trap
priv_switch  out  1  one-cycle pulse in the first cycle the new priv_rval is visible
settle_busy  out  1  high during the settle window

Behaviour:
- Reset values: priv_rval=M; MPP=U if HAS_U else M; SPP/MIE/SIE/MPIE/SPIE=0; trap_target=M; priv_switch/xret_illegal/settle_busy=0; FSM=IDLE.
- All state updates are registered. An event sampled in cycle N is visible on the outputs in cycle N+1.
- Trap target is S iff HAS_S, cur!=M, and the indexed deleg bit is 1. Otherwise the target is M. A cause index >= NUM_CAUSES counts as not delegated.
- Trap to M: MPP<=cur, MPIE<=MIE, MIE<=0, priv<=M.
- Trap to S: SPP<=cur[0], SPIE<=SIE, SIE<=0, priv<=S.
- A trap is always accepted, including during settle_busy. An accepted trap restarts the settle window.
- MRET, accepted only when cur==M: priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=(HAS_U?U:M).
- SRET, accepted only when HAS_S && cur>=S: priv<={1'b0,SPP}, SIE<=SPIE, SPIE<=1, SPP<=0.
- Any other accepted xRET, including an unknown xret_kind: state unchanged, xret_illegal pulses.
- An xRET is accepted only on xret_valid && xret_ready.
- Same-cycle priority: trap > xRET > CSR write. A lower event loses that cycle:
  - The xRET is not accepted and stays pending.
  - The CSR write is dropped.
- CSR write is WARL on MPP:
  - 2'b10 keeps the old value.
  - 2'b01 keeps the old value when !HAS_S.
  - 2'b00 keeps the old value when !HAS_U.
  - With HAS_S=0, S fields are forced to 0.
- A CSR write never changes priv_rval and never triggers settle.
- FSM IDLE to SETTLE on any accepted trap or accepted legal xRET. A same-level switch (e.g. M trap from M) still counts as a switch.
- SETTLE: counter loads SETTLE_CYCLES-1 and decrements; at 0 the FSM returns to IDLE. settle_busy is high for exactly SETTLE_CYCLES cycles, starting with the priv_switch cycle.
- Reset mid-SETTLE returns to reset values the next cycle, with no priv_switch pulse.

Optional Feature:
PRIV_DEBUG_EN adds these ports:
- debug_enter in 1
- dret_valid in 1
- debug_mode out 1
- dcsr_prv out 2

With the macro:
- debug_enter sets dcsr_prv<=cur, priv<=M and debug_mode<=1, and triggers settle.
- While debug_mode=1, traps update nothing and xRET pulses xret_illegal.
- dret_valid while debug_mode=1 restores priv<=dcsr_prv and clears debug_mode, with settle.
- debug_enter has priority over trap_valid.

Without the macro the ports are absent and behaviour is as above.

Decomposition:
- HART_DEFS: privilege_level_e, xret_kind_e, priv_status_t (mpp[1:0], spp, mie, sie, mpie, spie).
- COMMON_PARAMS: reset defaults.
- Sub-module priv_trap_target: combinational delegation and target decode from cur, trap_is_int, trap_cause, medeleg and mideleg.

Test Plan:
- Reset, then ECALL cause 8 from M with medeleg[8]=1 -> next cycle priv_rval=M, MPP=M, priv_switch=1, settle_busy high 2 cycles.
- MPP written 00, MPIE=1, then MRET -> priv_rval=U, MIE=1, MPIE=1, MPP=00.
- In U with medeleg[8]=1 and SIE=1, trap cause 8 -> priv_rval=S, SPP=0, SPIE=1, SIE=0, trap_target=S. Then SRET -> priv_rval=U.
- SRET from U -> xret_illegal pulse, priv_rval unchanged, no priv_switch. With HAS_S=0, trap with deleg all-ones -> target M.
- trap_valid, xret_valid and status_w_en in the same cycle -> trap applied, CSR write dropped, xRET accepted only after 2 settle cycles. MPP write 2'b10 -> MPP unchanged.
- With PRIV_DEBUG_EN: debug_enter from S -> priv_rval=M, dcsr_prv=S. A trap while in debug is ignored. dret -> priv_rval=S, debug_mode=0.

Source files
------------

// File: rtl/priv_mode_ctrl_pkg.sv
// Shared hart privilege types, reset defaults and settle FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package priv_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } privilege_level_e;

  typedef enum logic [1:0] {
    XRET_SRET = 2'b01,
    XRET_MRET = 2'b11
  } xret_kind_e;

  typedef struct packed {
    logic [1:0] mpp;
    logic       spp;
    logic       mie;
    logic       sie;
    logic       mpie;
    logic       spie;
  } priv_status_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } settle_state_e;

  localparam logic [1:0] RST_PRIV   = PRIV_M;
  localparam logic [1:0] RST_TARGET = PRIV_M;

  // Without U-mode the only legal MPP value is M.
  function automatic priv_status_t rst_status(input bit has_u);
    rst_status     = '0;
    rst_status.mpp = has_u ? PRIV_U : PRIV_M;
  endfunction

endpackage

// File: rtl/priv_mode_ctrl_trap_target.sv
// Trap delegation decode: picks S or M as the target level of a trap.
// Latency: purely combinational.
// Backpressure: none.
module priv_trap_target
  import priv_mode_ctrl_pkg::*;
#(
  parameter bit HAS_S      = 1'b1,
  parameter int CAUSE_W    = 6,
  parameter int NUM_CAUSES = 64
) (
  input  logic [1:0]            cur_i,
  input  logic                  is_int_i,
  input  logic [CAUSE_W-1:0]    cause_i,
  input  logic [NUM_CAUSES-1:0] medeleg_i,
  input  logic [NUM_CAUSES-1:0] mideleg_i,
  output logic [1:0]            target_o
);

  logic deleg_bit;

  // Select the delegation bit; causes beyond the vector read as not delegated.
  always_comb begin
    deleg_bit = 1'b0;
    for (int i = 0; i < NUM_CAUSES; i++) begin
      if (int'(cause_i) == i) begin
        deleg_bit = is_int_i ? mideleg_i[i] : medeleg_i[i];
      end
    end
  end

  assign target_o = (HAS_S && (cur_i != PRIV_M) && deleg_bit) ? PRIV_S : PRIV_M;

endmodule

// File: rtl/priv_mode_ctrl.sv
// Hart privilege-mode controller: trap entry, MRET/SRET, WARL status writes, settle window.
// Latency: every event sampled in cycle N is visible in cycle N+1; settle_busy spans SETTLE_CYCLES.
// Backpressure: xret_ready drops while settling; traps are never stalled. Optional debug: PRIV_DEBUG_EN.
module priv_mode_ctrl
  import priv_mode_ctrl_pkg::*;
#(
  parameter bit HAS_S         = 1'b1,
  parameter bit HAS_U         = 1'b1,
  parameter int CAUSE_W       = 6,
  parameter int NUM_CAUSES    = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trap_valid,
  input  logic                  trap_is_int,
  input  logic [CAUSE_W-1:0]    trap_cause,
  input  logic [NUM_CAUSES-1:0] medeleg,
  input  logic [NUM_CAUSES-1:0] mideleg,
  input  logic                  xret_valid,
  input  logic [1:0]            xret_kind,
  output logic                  xret_ready,
  output logic                  xret_illegal,
  input  logic                  status_w_en,
  input  priv_status_t          status_w,
  output logic [1:0]            priv_rval,
  output priv_status_t          status_rval,
  output logic [1:0]            trap_target,
  output logic                  priv_switch,
  output logic                  settle_busy
`ifdef PRIV_DEBUG_EN
  ,
  input  logic                  debug_enter,
  input  logic                  dret_valid,
  output logic                  debug_mode,
  output logic [1:0]            dcsr_prv
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]    priv_q, priv_d;
  logic [1:0]    target_q, target_d;
  priv_status_t  status_q, status_d;
  logic          switch_q, illegal_q, illegal_d;
  settle_state_e fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]    trap_tgt, new_mpp;
  logic          trap_take, xret_take, xret_blocked, settle_start;
  logic          mret_ok, sret_ok;

  priv_trap_target #(
    .HAS_S     (HAS_S),
    .CAUSE_W   (CAUSE_W),
    .NUM_CAUSES(NUM_CAUSES)
  ) u_trap_target (
    .cur_i    (priv_q),
    .is_int_i (trap_is_int),
    .cause_i  (trap_cause),
    .medeleg_i(medeleg),
    .mideleg_i(mideleg),
    .target_o (trap_tgt)
  );

  assign settle_busy = (fsm_q == ST_SETTLE);
  assign xret_ready  = !settle_busy;

`ifdef PRIV_DEBUG_EN
  logic       dbg_q, dbg_d;
  logic [1:0] dcsr_q, dcsr_d;
  logic       dbg_enter_take, dret_take;

  // Re-entering debug while already in it would clobber the saved level, so it is ignored.
  assign dbg_enter_take = debug_enter && !dbg_q;
  assign dret_take      = dret_valid && dbg_q;
  assign trap_take      = trap_valid && !dbg_q && !dbg_enter_take;
  assign xret_take      = xret_valid && xret_ready && !trap_take && !dbg_enter_take && !dret_take;
  assign xret_blocked   = dbg_q;
  assign debug_mode     = dbg_q;
  assign dcsr_prv       = dcsr_q;
`else
  assign trap_take      = trap_valid;
  assign xret_take      = xret_valid && xret_ready && !trap_take;
  assign xret_blocked   = 1'b0;
`endif

  assign mret_ok = !xret_blocked && (xret_kind == XRET_MRET) && (priv_q == PRIV_M);
  assign sret_ok = !xret_blocked && HAS_S && (xret_kind == XRET_SRET) && (priv_q >= PRIV_S);

  // WARL filter on MPP: unsupported encodings keep the current value.
  always_comb begin
    new_mpp = status_w.mpp;
    if ((status_w.mpp == 2'b10) ||
        ((status_w.mpp == PRIV_S) && !HAS_S) ||
        ((status_w.mpp == PRIV_U) && !HAS_U)) begin
      new_mpp = status_q.mpp;
    end
  end

  // Next privilege/status: debug > trap > xRET > CSR write, one event per cycle.
  always_comb begin
    priv_d       = priv_q;
    status_d     = status_q;
    target_d     = target_q;
    illegal_d    = 1'b0;
    settle_start = 1'b0;
`ifdef PRIV_DEBUG_EN
    dbg_d        = dbg_q;
    dcsr_d       = dcsr_q;
    if (dbg_enter_take) begin
      dcsr_d       = priv_q;
      dbg_d        = 1'b1;
      priv_d       = PRIV_M;
      settle_start = 1'b1;
    end else if (dret_take) begin
      dbg_d        = 1'b0;
      priv_d       = dcsr_q;
      settle_start = 1'b1;
    end else
`endif
    if (trap_take) begin
      target_d     = trap_tgt;
      priv_d       = trap_tgt;
      settle_start = 1'b1;
      if (trap_tgt == PRIV_S) begin
        status_d.spp  = priv_q[0];
        status_d.spie = status_q.sie;
        status_d.sie  = 1'b0;
      end else begin
        status_d.mpp  = priv_q;
        status_d.mpie = status_q.mie;
        status_d.mie  = 1'b0;
      end
    end else if (xret_take) begin
      if (mret_ok) begin
        priv_d        = status_q.mpp;
        status_d.mie  = status_q.mpie;
        status_d.mpie = 1'b1;
        status_d.mpp  = HAS_U ? PRIV_U : PRIV_M;
        settle_start  = 1'b1;
      end else if (sret_ok) begin
        priv_d        = {1'b0, status_q.spp};
        status_d.sie  = status_q.spie;
        status_d.spie = 1'b1;
        status_d.spp  = 1'b0;
        settle_start  = 1'b1;
      end else begin
        illegal_d     = 1'b1;
      end
    end else if (status_w_en) begin
      status_d.mpp  = new_mpp;
      status_d.mie  = status_w.mie;
      status_d.mpie = status_w.mpie;
      status_d.spp  = HAS_S ? status_w.spp  : 1'b0;
      status_d.sie  = HAS_S ? status_w.sie  : 1'b0;
      status_d.spie = HAS_S ? status_w.spie : 1'b0;
    end
  end

  // Settle window: any switch (re)loads the countdown, expiry returns to idle.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    if (settle_start) begin
      fsm_d = ST_SETTLE;
      cnt_d = CNT_LOAD;
    end else if (fsm_q == ST_SETTLE) begin
      if (cnt_q == '0) begin
        fsm_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      priv_q    <= RST_PRIV;
      status_q  <= rst_status(HAS_U);
      target_q  <= RST_TARGET;
      switch_q  <= 1'b0;
      illegal_q <= 1'b0;
      fsm_q     <= ST_IDLE;
      cnt_q     <= '0;
    end else begin
      priv_q    <= priv_d;
      status_q  <= status_d;
      target_q  <= target_d;
      switch_q  <= settle_start;
      illegal_q <= illegal_d;
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef PRIV_DEBUG_EN
  // Debug-mode flag and saved privilege level.
  always_ff @(posedge clock) begin
    if (reset) begin
      dbg_q  <= 1'b0;
      dcsr_q <= RST_PRIV;
    end else begin
      dbg_q  <= dbg_d;
      dcsr_q <= dcsr_d;
    end
  end
`endif

  assign priv_rval    = priv_q;
  assign status_rval  = status_q;
  assign trap_target  = target_q;
  assign priv_switch  = switch_q;
  assign xret_illegal = illegal_q;

endmodule
